hazard_ctrl: RTL

Pipeline hazard and stall controller for the five-stage core. It tracks in-flight register writes in a 3-entry scoreboard covering ID/EX, EX/MEM and MEM/WB, and detects read-after-write hazards against the instruction in decode. It sequences stalls, branch/jump flushes, data-memory wait and halt. It drives the decode stage's `stallCtrl`/`jumpFlush` inputs and the PC and IF/ID register enables.

---
 rtl/hazard_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the five-stage pipeline.
//
// A 3-entry scoreboard (ID/EX, EX/MEM, MEM/WB) tracks in-flight register
// writes. Read-after-write hazards are detected against the instruction
// currently in decode. The block also sequences branch/jump flushes,
// data-memory wait and HALT.
//
// Parameters
//   FWD          0: no forwarding, so any valid scoreboard match stalls.
//                1: forwarding present, so only a load in ID/EX stalls.
// Ports
//   clk, rst     clock; synchronous active-high reset
//   instr_IFID   decode instruction (rs = [10:8], rt = [7:5])
//   rsUsed/rtUsed, RegWrite, WrR, MemRead, Jump, halt_IFID
//                decode-stage attributes
//   takeBranch   branch in EX resolved taken this cycle
//   memStall     data memory busy; the whole pipe freezes
//   stallCtrl    insert a bubble into ID/EX
//   jumpFlush    squash IF/ID behind a jump
//   flushIFID    squash IF/ID for a taken branch
//   pcEn, ifidEn, pipeEn
//                register load enables
//   halted       HALT has retired; sticky until rst
//   o_dbg_state  FSM state (0 RUN, 1 FLUSH, 2 MEMWAIT, 3 HALT)
//   o_dbg_sb_v   scoreboard valid bits {MEMWB, EXMEM, IDEX}
//
// Handshake: none. The enables are plain level controls that take effect on
// the next rising edge. Outputs are combinational from registered state and
// the current inputs.
module hazard_ctrl #(
  parameter int FWD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_IFID,
  input  logic        rsUsed,
  input  logic        rtUsed,
  input  logic        RegWrite,
  input  logic [2:0]  WrR,
  input  logic        MemRead,
  input  logic        Jump,
  input  logic        halt_IFID,
  input  logic        takeBranch,
  input  logic        memStall,
  output logic        stallCtrl,
  output logic        jumpFlush,
  output logic        flushIFID,
  output logic        pcEn,
  output logic        ifidEn,
  output logic        pipeEn,
  output logic        halted,
  output logic [1:0]  o_dbg_state,
  output logic [2:0]  o_dbg_sb_v
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t r_state, r_ret;
  state_t w_next, w_ret_next, w_eff;

  logic       r_idex_v,  r_exmem_v,  r_memwb_v;
  logic [2:0] r_idex_d,  r_exmem_d,  r_memwb_d;
  logic       r_idex_ld, r_exmem_ld, r_memwb_ld;
  logic       r_mk_idex, r_mk_exmem, r_mk_memwb;
  logic       r_halted;

  logic [2:0] w_rs, w_rt;
  logic       w_m_rs, w_m_rt, w_haz, w_bubble, w_mk_in;
  logic       w_unused_instr;

  assign w_rs = instr_IFID[10:8];
  assign w_rt = instr_IFID[7:5];
  assign w_unused_instr = ^{instr_IFID[15:11], instr_IFID[4:0]};

  // With forwarding, only a load still in ID/EX cannot be bypassed in time.
  always_comb begin
    if (FWD == 0) begin
      w_m_rs = (r_idex_v  && (r_idex_d  == w_rs)) ||
               (r_exmem_v && (r_exmem_d == w_rs)) ||
               (r_memwb_v && (r_memwb_d == w_rs));
      w_m_rt = (r_idex_v  && (r_idex_d  == w_rt)) ||
               (r_exmem_v && (r_exmem_d == w_rt)) ||
               (r_memwb_v && (r_memwb_d == w_rt));
    end else begin
      w_m_rs = r_idex_v && r_idex_ld && (r_idex_d == w_rs);
      w_m_rt = r_idex_v && r_idex_ld && (r_idex_d == w_rt);
    end
  end

  assign w_haz = (rsUsed && w_m_rs) || (rtUsed && w_m_rt);

  // MEMWAIT is transparent once memStall drops: the saved state acts in the
  // same cycle, so no cycle is lost on the way out of the wait.
  assign w_eff = (r_state == S_MEMWAIT) ? r_ret : r_state;

  // Process 1: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_ret   <= S_RUN;
    end else begin
      r_state <= w_next;
      r_ret   <= w_ret_next;
    end
  end

  // Process 2: next-state logic
  always_comb begin
    w_next     = r_state;
    w_ret_next = r_ret;
    if (memStall) begin
      if (w_eff != S_HALT) begin
        w_next     = S_MEMWAIT;
        w_ret_next = w_eff;
      end
    end else begin
      case (w_eff)
        S_RUN: begin
          if (takeBranch)                w_next = S_FLUSH;
          else if (halt_IFID && !w_haz)  w_next = S_HALT;
          else                           w_next = S_RUN;
        end
        S_FLUSH: w_next = S_RUN;
        S_HALT:  w_next = S_HALT;
        default: w_next = S_RUN;
      endcase
    end
  end

  // Process 3: output decode. A hazard is resolved before a jump redirects,
  // so it is tested ahead of Jump.
  always_comb begin
    stallCtrl = 1'b0;
    jumpFlush = 1'b0;
    flushIFID = 1'b0;
    pcEn      = 1'b0;
    ifidEn    = 1'b0;
    pipeEn    = 1'b0;
    if (memStall) begin
      // all zero: freeze
    end else if (w_eff == S_HALT) begin
      stallCtrl = 1'b1;
      pipeEn    = 1'b1;
    end else if (takeBranch || (w_eff == S_FLUSH)) begin
      flushIFID = 1'b1;
      stallCtrl = 1'b1;
      pcEn      = 1'b1;
      ifidEn    = 1'b1;
      pipeEn    = 1'b1;
    end else if (w_haz) begin
      stallCtrl = 1'b1;
      pipeEn    = 1'b1;
    end else if (halt_IFID) begin
      // HALT moves into ID/EX; nothing behind it is fetched.
      pipeEn    = 1'b1;
    end else if (Jump) begin
      jumpFlush = 1'b1;
      pcEn      = 1'b1;
      ifidEn    = 1'b1;
      pipeEn    = 1'b1;
    end else begin
      pcEn      = 1'b1;
      ifidEn    = 1'b1;
      pipeEn    = 1'b1;
    end
  end

  assign w_bubble = stallCtrl || flushIFID || (w_eff == S_FLUSH);
  assign w_mk_in  = (w_eff == S_RUN) && (w_next == S_HALT);

  // Scoreboard and HALT marker shift together whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_v   <= 1'b0; r_exmem_v  <= 1'b0; r_memwb_v  <= 1'b0;
      r_idex_d   <= 3'd0; r_exmem_d  <= 3'd0; r_memwb_d  <= 3'd0;
      r_idex_ld  <= 1'b0; r_exmem_ld <= 1'b0; r_memwb_ld <= 1'b0;
      r_mk_idex  <= 1'b0; r_mk_exmem <= 1'b0; r_mk_memwb <= 1'b0;
      r_halted   <= 1'b0;
    end else if (pipeEn) begin
      r_idex_v   <= RegWrite && !w_bubble;
      r_idex_d   <= WrR;
      r_idex_ld  <= MemRead;
      r_exmem_v  <= r_idex_v;
      r_exmem_d  <= r_idex_d;
      r_exmem_ld <= r_idex_ld;
      r_memwb_v  <= r_exmem_v;
      r_memwb_d  <= r_exmem_d;
      r_memwb_ld <= r_exmem_ld;
      r_mk_idex  <= w_mk_in;
      r_mk_exmem <= r_mk_idex;
      r_mk_memwb <= r_mk_exmem;
      // The marker leaving MEM/WB means HALT has retired.
      if (r_mk_memwb) r_halted <= 1'b1;
    end
  end

  logic w_unused_ld;
  assign w_unused_ld = r_exmem_ld ^ r_memwb_ld;

  assign halted      = r_halted;
  assign o_dbg_state = r_state;
  assign o_dbg_sb_v  = {r_memwb_v, r_exmem_v, r_idex_v};

endmodule
